// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the jtdsp16 program-ROM arbiter: owner ids,
// arbiter FSM states and default parameter values.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    OWN_TBL   = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2,
    OWN_PF    = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  localparam logic [15:0]  DUMMY_DEF   = 16'hFFFF;
  localparam int unsigned  TIMEOUT_DEF = 63;

endpackage

// File: rtl/jtdsp16_rom_slot.sv
// One cached ROM word: tag/valid/data registers plus the combinational
// "word valid for the address currently requested" compare.
module jtdsp16_rom_slot (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clr_i,
  input  logic [15:0] tag_i,
  input  logic [15:0] data_i,
  input  logic        req_i,
  input  logic [15:0] addr_i,
  output logic        ok_o,
  output logic [15:0] data_o
);

  logic        valid_q;
  logic [15:0] tag_q;
  logic [15:0] data_q;

  // Capture a returned word under its tag; clear only drops validity.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      tag_q   <= tag_i;
      data_q  <= data_i;
    end
  end

  assign ok_o   = req_i && valid_q && (addr_i == tag_q);
  assign data_o = data_q;

endmodule

// File: rtl/jtdsp16_rom_arb.sv
// Program-ROM port arbiter for jtdsp16: table > fetch > debug, one access
// at a time, one idle cycle of mem_cs between accesses, timeout with a
// dummy word. Define JTDSP16_ROM_PREFETCH_EN to add a sequential
// instruction prefetch slot.
module jtdsp16_rom_arb
  import jtdsp16_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter logic [15:0] DUMMY   = DUMMY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic [15:0] fetch_dout,
  output logic        fetch_ok,
  input  logic        tbl_req,
  input  logic [15:0] tbl_addr,
  output logic [15:0] tbl_dout,
  output logic        tbl_ok,
  input  logic        dbg_req,
  input  logic [15:0] dbg_addr,
  output logic [15:0] dbg_dout,
  output logic        dbg_ok,
  output logic        stall,
  output logic        mem_cs,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_ok,
  output logic        tmo_err
);

  localparam logic [5:0] TMO = 6'(TIMEOUT);

  state_e      state_q;
  owner_e      owner_q;
  logic        mem_cs_q;
  logic [15:0] mem_addr_q;
  logic [5:0]  cnt_q;
  logic        tmo_q;

  logic        need_t, need_f, need_d, need_f_dem;
  logic        done;
  logic [15:0] wdata;
  logic        pick_vld;
  owner_e      pick_own;
  logic [15:0] pick_addr;
  logic        ld_tbl, ld_fetch, ld_dbg;
  logic [15:0] f_tag, f_data;

  assign need_t = tbl_req   && !tbl_ok;
  assign need_f = fetch_req && !fetch_ok;
  assign need_d = dbg_req   && !dbg_ok;
  assign stall  = need_f || need_t;

  assign done   = (state_q == ST_ACCESS) && (mem_ok || (cnt_q == TMO));
  assign wdata  = mem_ok ? mem_data : DUMMY;
  assign ld_tbl = done && (owner_q == OWN_TBL);
  assign ld_dbg = done && (owner_q == OWN_DBG);

`ifdef JTDSP16_ROM_PREFETCH_EN
  logic        pf_ok, pf_hit, ld_pf;
  logic [15:0] pf_data;
  logic        pf_pend_q;
  logic [15:0] pf_base_q;

  // A prefetch hit is copied into the fetch slot without touching memory.
  assign pf_hit     = (state_q == ST_IDLE) && need_f && pf_ok;
  assign need_f_dem = need_f && !pf_ok;
  assign ld_pf      = done && (owner_q == OWN_PF);
  assign ld_fetch   = (done && (owner_q == OWN_FETCH)) || pf_hit;
  assign f_tag      = pf_hit ? fetch_addr : mem_addr_q;
  assign f_data     = pf_hit ? pf_data : wdata;

  jtdsp16_rom_slot u_pf (
    .clk_i(clk), .rst_i(rst), .load_i(ld_pf), .clr_i(pf_hit),
    .tag_i(mem_addr_q), .data_i(wdata), .req_i(fetch_req),
    .addr_i(fetch_addr), .ok_o(pf_ok), .data_o(pf_data)
  );

  // Remember the last completed fetch address until its successor is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_pend_q <= 1'b0;
      pf_base_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && pick_vld && (pick_own == OWN_PF))
        pf_pend_q <= 1'b0;
      if (ld_fetch) begin
        pf_pend_q <= 1'b1;
        pf_base_q <= f_tag;
      end
    end
  end
`else
  assign need_f_dem = need_f;
  assign ld_fetch   = done && (owner_q == OWN_FETCH);
  assign f_tag      = mem_addr_q;
  assign f_data     = wdata;
`endif

  // Fixed-priority selection of the next access to issue from IDLE.
  always_comb begin
    pick_vld  = 1'b0;
    pick_own  = OWN_TBL;
    pick_addr = '0;
    if (need_t) begin
      pick_vld  = 1'b1;
      pick_own  = OWN_TBL;
      pick_addr = tbl_addr;
    end else if (need_f_dem) begin
      pick_vld  = 1'b1;
      pick_own  = OWN_FETCH;
      pick_addr = fetch_addr;
    end else if (need_d) begin
      pick_vld  = 1'b1;
      pick_own  = OWN_DBG;
      pick_addr = dbg_addr;
`ifdef JTDSP16_ROM_PREFETCH_EN
    end else if (pf_pend_q) begin
      pick_vld  = 1'b1;
      pick_own  = OWN_PF;
      pick_addr = pf_base_q + 16'd1;
`endif
    end
  end

  // Access sequencer: IDLE issues, ACCESS waits for data or timeout, GAP idles cs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_TBL;
      mem_cs_q   <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            mem_addr_q <= pick_addr;
            owner_q    <= pick_own;
            mem_cs_q   <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem_ok || (cnt_q == TMO)) begin
            mem_cs_q <= 1'b0;
            state_q  <= ST_GAP;
            if (!mem_ok) tmo_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        ST_GAP:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  jtdsp16_rom_slot u_tbl (
    .clk_i(clk), .rst_i(rst), .load_i(ld_tbl), .clr_i(1'b0),
    .tag_i(mem_addr_q), .data_i(wdata), .req_i(tbl_req),
    .addr_i(tbl_addr), .ok_o(tbl_ok), .data_o(tbl_dout)
  );

  jtdsp16_rom_slot u_fetch (
    .clk_i(clk), .rst_i(rst), .load_i(ld_fetch), .clr_i(1'b0),
    .tag_i(f_tag), .data_i(f_data), .req_i(fetch_req),
    .addr_i(fetch_addr), .ok_o(fetch_ok), .data_o(fetch_dout)
  );

  jtdsp16_rom_slot u_dbg (
    .clk_i(clk), .rst_i(rst), .load_i(ld_dbg), .clr_i(1'b0),
    .tag_i(mem_addr_q), .data_i(wdata), .req_i(dbg_req),
    .addr_i(dbg_addr), .ok_o(dbg_ok), .data_o(dbg_dout)
  );

  assign mem_cs   = mem_cs_q;
  assign mem_addr = mem_addr_q;
  assign tmo_err  = tmo_q;

endmodule

// File: tb/tb_jtdsp16_rom_arb.sv
// Self-checking bench for jtdsp16_rom_arb (default build, no prefetch).
// A memory model answers accesses; a monitor checks issued addresses
// against a queue of expected accesses.
module tb_jtdsp16_rom_arb;

  logic        clk, rst;
  logic        fetch_req, tbl_req, dbg_req;
  logic [15:0] fetch_addr, tbl_addr, dbg_addr;
  logic [15:0] fetch_dout, tbl_dout, dbg_dout;
  logic        fetch_ok, tbl_ok, dbg_ok, stall;
  logic        mem_cs, mem_ok, tmo_err;
  logic [15:0] mem_addr, mem_data;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] exp_q[$];
  int          lat      = 2;
  bit          mem_en   = 1'b1;
  int          spur_req = 0;

  jtdsp16_rom_arb dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_dout(fetch_dout), .fetch_ok(fetch_ok),
    .tbl_req(tbl_req), .tbl_addr(tbl_addr), .tbl_dout(tbl_dout), .tbl_ok(tbl_ok),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_dout(dbg_dout), .dbg_ok(dbg_ok),
    .stall(stall), .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ok(mem_ok), .tmo_err(tmo_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] word(input logic [15:0] a);
    return a ^ 16'hA5B5;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Memory: answers after 'lat' cycles of mem_cs, or never when disabled.
  initial begin
    int mcnt;
    int spur_seen;
    mcnt = 0;
    spur_seen = 0;
    mem_ok = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        mem_ok    = 1'b1;
        mem_data  = 16'h1234;
      end else if (mem_cs && mem_en) begin
        mcnt++;
        if (mcnt == lat) begin
          mem_ok   = 1'b1;
          mem_data = word(mem_addr);
          mcnt     = 0;
        end else begin
          mem_ok = 1'b0;
        end
      end else begin
        mem_ok = 1'b0;
        mcnt   = 0;
      end
    end
  end

  // Access monitor: each new mem_cs must match the next expected address.
  initial begin
    logic        cs_prev;
    logic [15:0] cur;
    cs_prev = 1'b0;
    cur     = '0;
    forever begin
      @(negedge clk);
      if (mem_cs && !cs_prev) begin
        cur = mem_addr;
        if (exp_q.size() == 0) check("unexpected_access", {16'h0, mem_addr}, 32'hFFFF_FFFF);
        else check("access_addr", {16'h0, mem_addr}, {16'h0, exp_q.pop_front()});
      end else if (mem_cs && cs_prev) begin
        check("addr_stable", {16'h0, mem_addr}, {16'h0, cur});
      end
      cs_prev = mem_cs;
    end
  end

  function automatic logic sel_ok(input int which);
    case (which)
      0:       return fetch_ok;
      1:       return tbl_ok;
      default: return dbg_ok;
    endcase
  endfunction

  // Wait (bounded) for a requester's ok; reports mem_ok one cycle earlier.
  task automatic wait_ok(input int which, input string nm, output logic prev_mok);
    logic pm;
    logic got;
    pm  = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel_ok(which)) begin
        got = 1'b1;
        break;
      end
      pm = mem_ok;
    end
    prev_mok = pm;
    check(nm, {31'h0, got}, 32'h1);
  endtask

  task automatic wait_cs(input string nm);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_cs) begin
        got = 1'b1;
        break;
      end
    end
    check(nm, {31'h0, got}, 32'h1);
  endtask

  typedef struct {
    logic        fr;
    logic [15:0] fa;
    logic        tr;
    logic [15:0] ta;
    logic        dr;
    logic [15:0] da;
    logic [3:0]  exp; // {fetch_ok, tbl_ok, dbg_ok, stall}
  } vec_t;

  vec_t vt[10];

  initial begin
    logic pm;
    int   ncs;
    logic done2;

    vt[0] = '{1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b1000};
    vt[1] = '{1'b1, 16'h8040, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b0001};
    vt[2] = '{1'b1, 16'h0040, 1'b1, 16'h0800, 1'b0, 16'h0000, 4'b1100};
    vt[3] = '{1'b0, 16'h0040, 1'b1, 16'h0801, 1'b0, 16'h0000, 4'b0001};
    vt[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0123, 4'b0010};
    vt[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0122, 4'b0000};
    vt[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b0000};
    vt[7] = '{1'b1, 16'h0041, 1'b1, 16'h0800, 1'b0, 16'h0000, 4'b0101};
    vt[8] = '{1'b0, 16'h0040, 1'b0, 16'h0800, 1'b0, 16'h0123, 4'b0000};
    vt[9] = '{1'b1, 16'h0040, 1'b1, 16'h0800, 1'b1, 16'h0123, 4'b1110};

    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    tbl_req = 1'b1;   tbl_addr = '0;
    dbg_req = 1'b0;   dbg_addr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_cs", {31'h0, mem_cs}, 32'h0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    check("rst_oks", {29'h0, fetch_ok, tbl_ok, dbg_ok}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h1);
    check("rst_tmo", {31'h0, tmo_err}, 32'h0);

    // Single fetch, data two cycles after mem_cs
    rst = 1'b0;
    tbl_req = 1'b0;
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    exp_q.push_back(16'h0010);
    wait_ok(0, "t1_fetch_ok", pm);
    check("t1_ok_after_mem_ok", {31'h0, pm}, 32'h1);
    check("t1_dout", {16'h0, fetch_dout}, 32'h0000_A5A5);
    check("t1_stall", {31'h0, stall}, 32'h0);

    // Simultaneous fetch and table: table first, then fetch after a gap
    fetch_addr = 16'h0020;
    tbl_req = 1'b1; tbl_addr = 16'h0800;
    exp_q.push_back(16'h0800);
    exp_q.push_back(16'h0020);
    #1;
    check("t2_fetch_ok_drop", {31'h0, fetch_ok}, 32'h0);
    done2 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fetch_ok && tbl_ok) begin
        done2 = 1'b1;
        break;
      end
      check("t2_stall_hi", {31'h0, stall}, 32'h1);
    end
    check("t2_both_ok", {31'h0, done2}, 32'h1);
    check("t2_stall_lo", {31'h0, stall}, 32'h0);
    check("t2_tbl_dout", {16'h0, tbl_dout}, {16'h0, word(16'h0800)});
    check("t2_fetch_dout", {16'h0, fetch_dout}, {16'h0, word(16'h0020)});

    // Debug request arriving during a fetch access waits for it
    fetch_addr = 16'h0040;
    exp_q.push_back(16'h0040);
    wait_cs("t3_cs");
    dbg_req = 1'b1; dbg_addr = 16'h0123;
    exp_q.push_back(16'h0123);
    #1;
    check("t3_dbg_not_ok", {31'h0, dbg_ok}, 32'h0);
    wait_ok(0, "t3_fetch_ok", pm);
    check("t3_dbg_waiting", {31'h0, dbg_ok}, 32'h0);
    wait_ok(2, "t3_dbg_ok", pm);
    check("t3_dbg_dout", {16'h0, dbg_dout}, {16'h0, word(16'h0123)});
    check("t3_fetch_dout", {16'h0, fetch_dout}, {16'h0, word(16'h0040)});

    // Combinational ok/stall vectors, applied and cleared within a low phase
    foreach (vt[i]) begin
      @(negedge clk);
      fetch_req = vt[i].fr; fetch_addr = vt[i].fa;
      tbl_req   = vt[i].tr; tbl_addr   = vt[i].ta;
      dbg_req   = vt[i].dr; dbg_addr   = vt[i].da;
      #1;
      check($sformatf("vec%0d", i), {28'h0, fetch_ok, tbl_ok, dbg_ok, stall}, {28'h0, vt[i].exp});
      #1;
      fetch_req = 1'b0; tbl_req = 1'b0; dbg_req = 1'b0;
    end

    // Fetch address change mid-hold
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 16'h0030;
    exp_q.push_back(16'h0030);
    wait_ok(0, "t5_fetch30_ok", pm);
    fetch_addr = 16'h0031;
    exp_q.push_back(16'h0031);
    #1;
    check("t5_ok_drop", {31'h0, fetch_ok}, 32'h0);
    check("t5_stall", {31'h0, stall}, 32'h1);
    wait_ok(0, "t5_fetch31_ok", pm);
    check("t5_dout", {16'h0, fetch_dout}, {16'h0, word(16'h0031)});

    // mem_ok outside an access is ignored
    spur_req++;
    repeat (3) @(negedge clk);
    check("spur_dout", {16'h0, fetch_dout}, {16'h0, word(16'h0031)});
    check("spur_ok", {31'h0, fetch_ok}, 32'h1);
    check("spur_tmo", {31'h0, tmo_err}, 32'h0);

    // Timeout: 64 ACCESS cycles then dummy word and sticky error
    mem_en = 1'b0;
    fetch_addr = 16'h0050;
    exp_q.push_back(16'h0050);
    ncs = 0;
    done2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fetch_ok) begin
        done2 = 1'b1;
        break;
      end
      if (mem_cs) ncs++;
    end
    check("tmo_done", {31'h0, done2}, 32'h1);
    check("tmo_cycles", ncs, 64);
    check("tmo_dout", {16'h0, fetch_dout}, 32'h0000_FFFF);
    check("tmo_err_set", {31'h0, tmo_err}, 32'h1);
    mem_en = 1'b1;
    fetch_addr = 16'h0060;
    exp_q.push_back(16'h0060);
    wait_ok(0, "tmo_next_ok", pm);
    check("tmo_next_dout", {16'h0, fetch_dout}, {16'h0, word(16'h0060)});
    check("tmo_err_sticky", {31'h0, tmo_err}, 32'h1);

    // Reset in the middle of an access
    lat = 10;
    fetch_addr = 16'h0070;
    exp_q.push_back(16'h0070);
    wait_cs("t6_cs");
    rst = 1'b1;
    #1;
    check("t6_cs_low", {31'h0, mem_cs}, 32'h0);
    check("t6_addr_zero", {16'h0, mem_addr}, 32'h0);
    check("t6_oks_low", {29'h0, fetch_ok, tbl_ok, dbg_ok}, 32'h0);
    check("t6_stall", {31'h0, stall}, 32'h1);
    check("t6_tmo_clr", {31'h0, tmo_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    lat = 2;
    exp_q.push_back(16'h0070);
    wait_ok(0, "t6_restart_ok", pm);
    check("t6_dout", {16'h0, fetch_dout}, {16'h0, word(16'h0070)});

    fetch_req = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtdsp16_rom_arb.md
Name: jtdsp16_rom_arb

Overview:
Arbiter and sequencer for the single external program-ROM port shared by three requesters:
- instruction fetch, driven by the PC from the ROM address unit;
- table reads (*pt++ / *pt++i), driven by the table pointer;
- a debug/host read port.

It issues one memory access at a time, latches returned words per requester and generates the core stall (pc_halt source). It sits between jtdsp16 core logic and the SDRAM/BRAM wrapper.

Parameters:
- TIMEOUT, 63: cycles to wait for mem_ok before aborting the access with a dummy word. Counter is 6 bits wide; the value must be below 64.
- DUMMY, 16'hFFFF: word returned on timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- fetch_req  in  1  instruction word wanted at fetch_addr
- fetch_addr  in  16  PC
- fetch_dout  out  16  instruction word
- fetch_ok  out  1  fetch_dout valid for current fetch_addr
- tbl_req  in  1  table read wanted
- tbl_addr  in  16  table pointer
- tbl_dout  out  16  table word
- tbl_ok  out  1  tbl_dout valid for current tbl_addr
- dbg_req  in  1  debug read
- dbg_addr  in  16  debug address
- dbg_dout  out  16  debug word
- dbg_ok  out  1  dbg_dout valid for current dbg_addr
- stall  out  1  core must hold PC (fetch or table word missing)
- mem_cs  out  1  external access request
- mem_addr  out  16  external address
- mem_data  in  16  external read data
- mem_ok  in  1  external data valid (one-cycle pulse)
- tmo_err  out  1  sticky: an access timed out

Behaviour:
- Per-requester tag/valid/data registers.
  - xx_ok = xx_req && valid_xx && (xx_addr == tag_xx). This is combinational: an address change drops ok in the same cycle.
  - stall = (fetch_req && !fetch_ok) || (tbl_req && !tbl_ok).
- A requester "needs" an access when req=1 and ok=0.
- FSM states IDLE, ACCESS, GAP.
  - IDLE: choose by fixed priority tbl > fetch > dbg. Latch mem_addr = chosen addr and the owner id, set mem_cs=1, clear the timeout counter, go to ACCESS.
  - ACCESS: mem_cs held high, mem_addr held stable.
    - On mem_ok: tag_owner <= mem_addr, data_owner <= mem_data, valid_owner <= 1, mem_cs <= 0, go to GAP.
    - On counter == TIMEOUT: same update with DUMMY, tmo_err <= 1, go to GAP.
  - GAP: one cycle with mem_cs=0 (wrapper handshake requirement), then IDLE.
- No preemption. A higher-priority need arriving during ACCESS waits for GAP→IDLE.
- If the owner's addr changes mid-access, the word is still stored under the old tag. ok stays low and a new access follows.
- Minimum latency: need detected in cycle 0 (IDLE) → mem_cs in cycle 1 → mem_ok in cycle k ≥ 2 → ok high in cycle k+1.
- mem_ok outside ACCESS is ignored.
- tmo_err is cleared only by rst.
- Reset (also mid-access): state IDLE, mem_cs=0, mem_addr=0, all valid=0, all tags/data=0, tmo_err=0, counter=0. Every *_ok=0 and stall=fetch_req||tbl_req.
- Tag compare uses full 16 bits. There is no wrap logic: the address is forwarded verbatim.

Optional Feature:
JTDSP16_ROM_PREFETCH_EN
- Defined: after a fetch completes at address A, when IDLE has no need, the block issues a speculative read of A+1 (16-bit wrap, FFFF→0000) into a prefetch slot (tag/valid/data).
  - A fetch need whose addr matches the prefetch tag is served by copying the slot into the fetch registers in one cycle, with no mem_cs.
  - A prefetch in flight completes normally; it is not preempted.
- Undefined: no slot and no speculative accesses. Only demand reads are issued.

Decomposition:
- Package jtdsp16_pkg: owner ids (OWN_TBL=0, OWN_FETCH=1, OWN_DBG=2, OWN_PF=3), FSM state encodings, default DUMMY constant.
- One natural sub-module, jtdsp16_rom_slot: tag/valid/data register with load, clear and the combinational ok compare. It is instantiated three times, or four with prefetch.

Test Plan:
- Reset, then fetch_req=1, fetch_addr=16'h0010, memory returns 16'hA5A5 two cycles after mem_cs → mem_cs for exactly one access, fetch_ok and fetch_dout=A5A5 one cycle after mem_ok, stall drops the same cycle.
- fetch (addr 0020) and tbl (addr 0800) raised in the same cycle → first mem_addr=0800, GAP cycle with mem_cs=0, then mem_addr=0020; stall high until both ok.
- dbg_req during an ACCESS for fetch → dbg is served only after fetch GAP; dbg_dout matches memory.
- mem_ok never returned → after TIMEOUT+1 ACCESS cycles, the owner gets 16'hFFFF, tmo_err=1 and stays 1 until rst.
- Fetch at 0030 held, then fetch_addr changes to 0031 → fetch_ok falls the same cycle and a new access is issued. With JTDSP16_ROM_PREFETCH_EN, 0031 is already prefetched and fetch_ok rises one cycle later with no mem_cs.
- rst asserted mid-ACCESS → mem_cs low immediately, all ok low; after release, a pending fetch restarts from IDLE.
